// File: rtl/prm_oblgc_chk_engine.sv
// Programmable sum-of-products obstacle checker: evaluates a query vector against a
// loadable term table, LANES terms per cycle, stopping at the lowest matching term.
module prm_oblgc_chk_engine #(
    parameter  int IN_W   = 15,
    parameter  int TERM_N = 256,
    parameter  int LANES  = 8,
    parameter  int TAG_W  = 8,
    localparam int AW     = $clog2(TERM_N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [IN_W-1:0]  cfg_care,
    input  logic [IN_W-1:0]  cfg_val,
    input  logic             cfg_cnt_we,
    input  logic [AW:0]      cfg_cnt,
    output logic             cfg_ready,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_vec,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mask,
    output logic [AW-1:0]    out_hit_idx,
    output logic [TAG_W-1:0] out_tag,
    output logic [31:0]      query_cnt,
    output logic [31:0]      hit_cnt,
    output logic [1:0]       dbg_state
);
    localparam int GRP_N = TERM_N / LANES;
    localparam int GW    = (GRP_N > 1) ? $clog2(GRP_N) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready/cfg_ready are high only in IDLE, out_valid only in DONE, never together.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_idle;
    logic               r_out_valid;
    logic               r_mask;
    logic [AW-1:0]      r_hit_idx;
    logic [TAG_W-1:0]   r_tag;
    logic [IN_W-1:0]    r_vec;
    logic [GW-1:0]      r_grp;
    logic [AW:0]        r_term_cnt;
    logic [31:0]        r_query_cnt;
    logic [31:0]        r_hit_cnt;
    logic [IN_W-1:0]    r_care [TERM_N];
    logic [IN_W-1:0]    r_val  [TERM_N];

    logic               w_addr_ok;
    logic [AW:0]        w_cnt_clip;
    logic [AW:0]        w_cnt_nxt;
    logic [AW:0]        w_base;
    logic [AW:0]        w_next_base;
    logic               w_last;
    logic               w_hit;
    logic [AW-1:0]      w_hit_idx;
    logic [AW:0]        w_idx;

    assign w_addr_ok   = ({1'b0, cfg_addr} < (AW+1)'(TERM_N));
    assign w_cnt_clip  = (cfg_cnt > (AW+1)'(TERM_N)) ? (AW+1)'(TERM_N) : cfg_cnt;
    // A count written in the accept cycle already governs that query.
    assign w_cnt_nxt   = (cfg_cnt_we && r_idle) ? w_cnt_clip : r_term_cnt;
    assign w_base      = (AW+1)'(r_grp) * (AW+1)'(LANES);
    assign w_next_base = w_base + (AW+1)'(LANES);
    assign w_last      = (w_next_base >= r_term_cnt);

    // Scan lanes high to low so the lowest matching index is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_idx     = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            w_idx = w_base + (AW+1)'(l);
            if ((w_idx < r_term_cnt) &&
                (((r_vec ^ r_val[w_idx[AW-1:0]]) & r_care[w_idx[AW-1:0]]) == '0)) begin
                w_hit     = 1'b1;
                w_hit_idx = w_idx[AW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cfg_we && r_idle && w_addr_ok) begin
            r_care[cfg_addr] <= cfg_care;
            r_val[cfg_addr]  <= cfg_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idle      <= 1'b1;
            r_out_valid <= 1'b0;
            r_mask      <= 1'b0;
            r_hit_idx   <= '0;
            r_tag       <= '0;
            r_vec       <= '0;
            r_grp       <= '0;
            r_term_cnt  <= '0;
            r_query_cnt <= '0;
            r_hit_cnt   <= '0;
        end else begin
            if (cfg_cnt_we && r_idle) begin
                r_term_cnt <= w_cnt_clip;
            end
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_vec     <= in_vec;
                        r_tag     <= in_tag;
                        r_grp     <= '0;
                        r_mask    <= 1'b0;
                        r_hit_idx <= '0;
                        r_idle    <= 1'b0;
                        r_state   <= (w_cnt_nxt == '0) ? S_DONE : S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_hit) begin
                        r_mask    <= 1'b1;
                        r_hit_idx <= w_hit_idx;
                        r_state   <= S_DONE;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                end
                S_DONE: begin
                    // Result registers settle on entry; out_valid follows one cycle later.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_idle      <= 1'b1;
                        r_state     <= S_IDLE;
                        if (r_query_cnt != '1) r_query_cnt <= r_query_cnt + 32'd1;
                        if (r_mask && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + 32'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_idle      <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready   = r_idle;
    assign in_ready    = r_idle;
    assign out_valid   = r_out_valid;
    assign out_mask    = r_mask;
    assign out_hit_idx = r_hit_idx;
    assign out_tag     = r_tag;
    assign query_cnt   = r_query_cnt;
    assign hit_cnt     = r_hit_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_prm_oblgc_chk_engine.sv
// Directed bench for prm_oblgc_chk_engine: hand-computed terms, queries, latencies and counters.
module tb_prm_oblgc_chk_engine;
    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [14:0] cfg_care;
    logic [14:0] cfg_val;
    logic        cfg_cnt_we;
    logic [8:0]  cfg_cnt;
    logic        cfg_ready;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_vec;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic        out_mask;
    logic [7:0]  out_hit_idx;
    logic [7:0]  out_tag;
    logic [31:0] query_cnt;
    logic [31:0] hit_cnt;
    logic [1:0]  dbg_state;

    int          n_checks;
    int          n_errors;
    int          exp_qc;
    int          exp_hc;
    logic [16:0] exp_q[$];

    prm_oblgc_chk_engine dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_care   (cfg_care),
        .cfg_val    (cfg_val),
        .cfg_cnt_we (cfg_cnt_we),
        .cfg_cnt    (cfg_cnt),
        .cfg_ready  (cfg_ready),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mask   (out_mask),
        .out_hit_idx(out_hit_idx),
        .out_tag    (out_tag),
        .query_cnt  (query_cnt),
        .hit_cnt    (hit_cnt),
        .dbg_state  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_term(input logic [7:0] addr, input logic [14:0] care, input logic [14:0] val);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_care = care;
        cfg_val  = val;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic write_cnt(input logic [8:0] cnt);
        @(negedge clk);
        cfg_cnt_we = 1'b1;
        cfg_cnt    = cnt;
        @(negedge clk);
        cfg_cnt_we = 1'b0;
    endtask

    task automatic start_query(input logic [14:0] vec, input logic [7:0] tag);
        @(negedge clk);
        check("in_ready_before_query", in_ready, 1'b1);
        in_valid = 1'b1;
        in_vec   = vec;
        in_tag   = tag;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts rising edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    task automatic finish_query();
        logic [16:0] e;
        check("out_valid", out_valid, 1'b1);
        e = exp_q.pop_front();
        if (out_valid) begin
            check("out_mask", out_mask, e[16]);
            check("out_hit_idx", out_hit_idx, e[15:8]);
            check("out_tag", out_tag, e[7:0]);
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
            exp_qc++;
            if (e[16]) exp_hc++;
            @(negedge clk);
            check("query_cnt", query_cnt, exp_qc);
            check("hit_cnt", hit_cnt, exp_hc);
            check("in_ready_after_done", in_ready, 1'b1);
        end
    endtask

    task automatic run_query(input logic [14:0] vec, input logic [7:0] tag,
                             input logic exp_mask, input logic [7:0] exp_idx, input int exp_lat);
        int lat;
        exp_q.push_back({exp_mask, exp_idx, tag});
        start_query(vec, tag);
        wait_valid(lat);
        check("latency", lat, exp_lat);
        finish_query();
    endtask

    initial begin
        int   lat;
        logic seen;
        n_checks = 0; n_errors = 0; exp_qc = 0; exp_hc = 0;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_care = '0; cfg_val = '0;
        cfg_cnt_we = 1'b0; cfg_cnt = '0; in_valid = 1'b0; in_vec = '0; in_tag = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_mask", out_mask, 1'b0);
        check("rst_out_hit_idx", out_hit_idx, 8'd0);
        check("rst_out_tag", out_tag, 8'd0);
        check("rst_query_cnt", query_cnt, 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_dbg_state", dbg_state, 2'd0);

        // !O&N&M&L&!J&I&H&!E&!C with bit0=A: care 0x7B94, val 0x3980.
        write_term(8'd0, 15'h7B94, 15'h3980);
        write_cnt(9'd1);
        run_query(15'h39E3, 8'h11, 1'b1, 8'd0, 2);
        run_query(15'h39E7, 8'h12, 1'b0, 8'd0, 2);
        run_query(15'h3980, 8'h13, 1'b1, 8'd0, 2);
        run_query(15'h68E3, 8'h14, 1'b0, 8'd0, 2);

        write_cnt(9'd0);
        run_query(15'h1234, 8'h5A, 1'b0, 8'd0, 1);

        for (int i = 0; i < 255; i++) write_term(8'(i), 15'h7FFF, 15'h7FFF);
        write_term(8'd255, 15'h0000, 15'h0000);
        write_cnt(9'd256);
        run_query(15'h0000, 8'h30, 1'b1, 8'd255, 33);

        write_term(8'd3, 15'h000F, 15'h0005);
        write_term(8'd6, 15'h00F0, 15'h0030);
        run_query(15'h0035, 8'h40, 1'b1, 8'd3, 2);
        write_cnt(9'd6);
        run_query(15'h0035, 8'h41, 1'b1, 8'd3, 2);
        write_term(8'd3, 15'h7FFF, 15'h7FFF);
        run_query(15'h0035, 8'h42, 1'b0, 8'd0, 2);
        write_cnt(9'd7);
        run_query(15'h0035, 8'h43, 1'b1, 8'd6, 2);

        // Stalled result: config traffic during the stall must be dropped.
        exp_q.push_back({1'b1, 8'd6, 8'h77});
        start_query(15'h0035, 8'h77);
        wait_valid(lat);
        check("stall_latency", lat, 2);
        for (int i = 0; i < 10; i++) begin
            cfg_we = 1'b1; cfg_addr = 8'd6; cfg_care = 15'h7FFF; cfg_val = 15'h7FFF;
            cfg_cnt_we = 1'b1; cfg_cnt = 9'd0;
            @(negedge clk);
            check("stall_outputs", {out_valid, out_mask, out_hit_idx, out_tag, in_ready, cfg_ready},
                  {1'b1, 1'b1, 8'd6, 8'h77, 1'b0, 1'b0});
            check("stall_query_cnt", query_cnt, exp_qc);
        end
        cfg_we = 1'b0; cfg_cnt_we = 1'b0;
        finish_query();
        run_query(15'h0035, 8'h78, 1'b1, 8'd6, 2);

        write_term(8'd255, 15'h7FFF, 15'h7FFF);
        write_cnt(9'd300);
        run_query(15'h0000, 8'h21, 1'b0, 8'd0, 33);

        write_cnt(9'd256);
        start_query(15'h0000, 8'h22);
        repeat (5) @(negedge clk);
        check("eval_before_rst", dbg_state, 2'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_query_cnt", query_cnt, 32'd0);
        check("rst_mid_hit_cnt", hit_cnt, 32'd0);
        rst = 1'b0;
        exp_qc = 0; exp_hc = 0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("post_rst_no_output", seen, 1'b0);
        run_query(15'h4321, 8'h5B, 1'b0, 8'd0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
